// File: rtl/pipe_pkg.sv
// Shared types and helpers for the valid/ready pipeline chain.
// Stage states, the capacity helper and the stage-count limit live here.
package pipe_pkg;

  localparam int MAX_STAGES = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  function automatic int pipe_capacity(input int stages, input bit reg_ready);
    return reg_ready ? 2 * stages : stages;
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One valid/ready stage: a 2-entry skid buffer (REG_READY=1) or a
// 1-entry pipeline register (REG_READY=0), with synchronous flush.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit REG_READY  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  stage_state_e          state_reg, state_next;
  logic [DATA_WIDTH-1:0] main_reg, main_next;
  logic [DATA_WIDTH-1:0] skid_reg, skid_next;
  logic                  in_xfer, out_xfer;

  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign count     = (state_reg == FULL) ? 2'd2 :
                     (state_reg == BUSY) ? 2'd1 : 2'd0;

  generate
    if (REG_READY) begin : g_skid
      assign in_ready = (state_reg != FULL);
    end else begin : g_single
      assign in_ready = (state_reg == EMPTY) || out_ready;
    end
  endgenerate

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  // In single-register mode BUSY only accepts when out_ready is high, so the
  // BUSY->FULL branch is unreachable and the same table serves both modes.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            state_next = BUSY;
            main_next  = in_data;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_next = in_data;
          end else if (in_xfer) begin
            state_next = FULL;
            skid_next  = in_data;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_next = BUSY;
            main_next  = skid_reg;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pipe_skid_chain.sv
// Chain of STAGES valid/ready stages with flush masking at both ends
// and a combinational occupancy count taken from the stage state flops.
module pipe_skid_chain
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 2,
  parameter bit REG_READY  = 1'b1,
  parameter int OCC_W      = $clog2(2 * STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OCC_W-1:0]      occupancy
);

  logic                  valid_link [STAGES+1];
  logic                  ready_link [STAGES+1];
  logic [DATA_WIDTH-1:0] data_link  [STAGES+1];
  logic [1:0]            count      [STAGES];

  // Flush blocks both external handshakes so nothing moves in that cycle.
  assign valid_link[0]      = in_valid && !flush;
  assign data_link[0]       = in_data;
  assign in_ready           = ready_link[0] && !flush;
  assign ready_link[STAGES] = out_ready && !flush;
  assign out_valid          = valid_link[STAGES] && !flush;
  assign out_data           = data_link[STAGES];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      pipe_skid_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_READY (REG_READY)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (valid_link[gi]),
        .in_ready (ready_link[gi]),
        .in_data  (data_link[gi]),
        .out_valid(valid_link[gi+1]),
        .out_ready(ready_link[gi+1]),
        .out_data (data_link[gi+1]),
        .count    (count[gi])
      );
    end
  endgenerate

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(count[i]);
    end
  end

endmodule

// File: tb/tb_pipe_skid_chain.sv
// Directed and randomized checks of pipe_skid_chain in four configurations,
// compared against a queue-based FIFO model.
module tb_pipe_skid_chain;
  import pipe_pkg::*;

  localparam int NI     = 4;
  localparam int NWORDS = 1000;

  logic clk;
  logic rst_n;
  logic flush;
  logic        iv   [NI];
  logic        irdy [NI];
  logic [31:0] id   [NI];
  logic        ov   [NI];
  logic        ordy [NI];
  logic [31:0] od   [NI];
  logic [7:0]  occ  [NI];
  logic [2:0]  occ0;
  logic [1:0]  occ1;
  logic [4:0]  occ2;
  logic [4:0]  occ3;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign occ[0] = 8'(occ0);
  assign occ[1] = 8'(occ1);
  assign occ[2] = 8'(occ2);
  assign occ[3] = 8'(occ3);

  pipe_skid_chain #(.DATA_WIDTH(32), .STAGES(2), .REG_READY(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .occupancy(occ0));
  pipe_skid_chain #(.DATA_WIDTH(32), .STAGES(1), .REG_READY(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .occupancy(occ1));
  pipe_skid_chain #(.DATA_WIDTH(32), .STAGES(8), .REG_READY(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .occupancy(occ2));
  pipe_skid_chain #(.DATA_WIDTH(32), .STAGES(8), .REG_READY(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv[3]), .in_ready(irdy[3]), .in_data(id[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .occupancy(occ3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < NI; i++) begin
      iv[i]   = 1'b0;
      id[i]   = '0;
      ordy[i] = 1'b1;
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model state for the randomized phase
  logic [31:0] q [NI][$];
  int          cap       [NI];
  int          sent      [NI];
  int          rcvd      [NI];
  logic        pend      [NI];
  logic        stall_prev[NI];
  logic [31:0] data_prev [NI];

  initial begin
    int  k;
    int  nout;
    logic acc;
    int  cyc;
    bit  done;

    cap[0] = pipe_capacity(2, 1'b1);
    cap[1] = pipe_capacity(1, 1'b0);
    cap[2] = pipe_capacity(8, 1'b1);
    cap[3] = pipe_capacity(8, 1'b0);

    // Reset values, observed while reset is held
    rst_n = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0; id[i] = '0; ordy[i] = 1'b1;
    end
    #2;
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_out_data", od[0], 32'd0);
    check("rst_occupancy", 32'(occ[0]), 32'd0);
    check("rst_in_ready", 32'(irdy[0]), 32'd1);
    check("rst_in_ready_single", 32'(irdy[1]), 32'd1);
    do_reset();

    // Single word latency through STAGES=2
    iv[0] = 1'b1; id[0] = 32'hA5A5_0001; ordy[0] = 1'b1;
    #1;
    check("lat_in_ready", 32'(irdy[0]), 32'd1);
    tick();
    iv[0] = 1'b0;
    #1;
    check("lat_c1_valid", 32'(ov[0]), 32'd0);
    check("lat_c1_occ", 32'(occ[0]), 32'd1);
    tick();
    #1;
    check("lat_c2_valid", 32'(ov[0]), 32'd1);
    check("lat_c2_data", od[0], 32'hA5A5_0001);
    tick();
    #1;
    check("lat_c3_occ", 32'(occ[0]), 32'd0);
    check("lat_c3_valid", 32'(ov[0]), 32'd0);

    // Back-to-back stream 1..16
    for (int c = 0; c < 18; c++) begin
      iv[0] = (c < 16);
      id[0] = 32'(c + 1);
      #1;
      if (c < 16) check("stream_in_ready", 32'(irdy[0]), 32'd1);
      check("stream_out_valid", 32'(ov[0]), 32'(c >= 2));
      if (c >= 2) check("stream_out_data", od[0], 32'(c - 1));
      tick();
    end
    iv[0] = 1'b0;
    #1;
    check("stream_drained", 32'(ov[0]), 32'd0);

    // Backpressure: only capacity words accepted, then drain in order
    ordy[0] = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      iv[0] = 1'b1;
      id[0] = 32'h100 + 32'(k);
      #1;
      acc = irdy[0];
      tick();
      if (acc) k++;
    end
    #1;
    check("bp_accepted", 32'(k), 32'd4);
    check("bp_in_ready", 32'(irdy[0]), 32'd0);
    check("bp_occupancy", 32'(occ[0]), 32'd4);
    ordy[0] = 1'b1;
    nout = 0;
    for (int c = 0; c < 40 && nout < 8; c++) begin
      iv[0] = (k < 8);
      id[0] = 32'h100 + 32'(k);
      #1;
      if (ov[0]) begin
        check("bp_out_data", od[0], 32'h100 + 32'(nout));
        nout++;
      end
      acc = iv[0] && irdy[0];
      tick();
      if (acc) k++;
    end
    iv[0] = 1'b0;
    check("bp_out_count", 32'(nout), 32'd8);
    tick();
    check("bp_empty", 32'(occ[0]), 32'd0);

    // Flush with 3 words held and a concurrent input offer
    ordy[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      iv[0] = 1'b1;
      id[0] = 32'h11 * 32'(j + 1);
      tick();
    end
    iv[0] = 1'b0;
    #1;
    check("fl_pre_occ", 32'(occ[0]), 32'd3);
    flush = 1'b1; iv[0] = 1'b1; id[0] = 32'hDEAD; ordy[0] = 1'b1;
    #1;
    check("fl_in_ready", 32'(irdy[0]), 32'd0);
    check("fl_out_valid", 32'(ov[0]), 32'd0);
    tick();
    flush = 1'b0; iv[0] = 1'b0;
    #1;
    check("fl_post_occ", 32'(occ[0]), 32'd0);
    for (int c = 0; c < 5; c++) begin
      check("fl_no_dead", 32'(ov[0]), 32'd0);
      tick();
    end
    iv[0] = 1'b1; id[0] = 32'h77;
    tick();
    iv[0] = 1'b0;
    tick();
    check("fl_resume_valid", 32'(ov[0]), 32'd1);
    check("fl_resume_data", od[0], 32'h77);
    tick();

    // Asynchronous reset mid-stream
    ordy[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      iv[0] = 1'b1;
      id[0] = 32'h31 + 32'(j);
      tick();
    end
    iv[0] = 1'b0;
    #1;
    check("ar_pre_occ", 32'(occ[0]), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(ov[0]), 32'd0);
    check("ar_occupancy", 32'(occ[0]), 32'd0);
    check("ar_out_data", od[0], 32'd0);
    do_reset();

    // Randomized traffic on all four configurations
    for (int i = 0; i < NI; i++) begin
      q[i].delete();
      sent[i] = 0; rcvd[i] = 0; pend[i] = 1'b0;
      stall_prev[i] = 1'b0; data_prev[i] = '0;
    end
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 20000) begin
      for (int i = 0; i < NI; i++) begin
        if (!pend[i] && sent[i] < NWORDS && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          id[i]   = $urandom;
        end
        iv[i]   = pend[i];
        ordy[i] = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (stall_prev[i]) begin
          check("rnd_hold_valid", 32'(ov[i]), 32'd1);
          check("rnd_hold_data", od[i], data_prev[i]);
        end
        if (ov[i]) begin
          check("rnd_not_spurious", 32'(q[i].size() > 0), 32'd1);
          if (q[i].size() > 0) check("rnd_out_data", od[i], q[i][0]);
          if (ordy[i] && q[i].size() > 0) begin
            void'(q[i].pop_front());
            rcvd[i]++;
          end
        end
        if (iv[i] && irdy[i]) begin
          q[i].push_back(id[i]);
          sent[i]++;
          pend[i] = 1'b0;
        end
        stall_prev[i] = ov[i] && !ordy[i];
        data_prev[i]  = od[i];
      end
      tick();
      done = 1'b1;
      for (int i = 0; i < NI; i++) begin
        check("rnd_occupancy", 32'(occ[i]), 32'(q[i].size()));
        check("rnd_cap_bound", 32'(int'(occ[i]) <= cap[i]), 32'd1);
        if (rcvd[i] < NWORDS) done = 1'b0;
      end
      cyc++;
    end
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0;
      check("rnd_words_received", 32'(rcvd[i]), 32'(NWORDS));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
